// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue interface: 2-wide fetch slots in, 2-wide decode slots out.
// Slot 0 is always the older of the pair.
interface fetch_queue_if #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                          ext_flush;
  logic                          ext_stall;
  logic [1:0]                    in_valid;
  logic [1:0][ADDR_WIDTH-1:0]    in_pc;
  logic [1:0][INSTR_WIDTH-1:0]   in_instr;
  logic [1:0]                    in_guesses_branch;
  logic [1:0][ADDR_WIDTH-1:0]    in_prediction;
  logic                          fq_stall;
  logic [1:0]                    out_valid;
  logic [1:0][ADDR_WIDTH-1:0]    out_pc;
  logic [1:0][INSTR_WIDTH-1:0]   out_instr;
  logic [1:0]                    out_guesses_branch;
  logic [1:0][ADDR_WIDTH-1:0]    out_prediction;
  logic [$clog2(DEPTH):0]        count;

  modport master (
    output ext_flush, ext_stall, in_valid, in_pc, in_instr, in_guesses_branch, in_prediction,
    input  fq_stall, out_valid, out_pc, out_instr, out_guesses_branch, out_prediction, count
  );

  modport slave (
    input  ext_flush, ext_stall, in_valid, in_pc, in_instr, in_guesses_branch, in_prediction,
    output fq_stall, out_valid, out_pc, out_instr, out_guesses_branch, out_prediction, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between 2-wide fetch and 2-wide decode.
// Compacts fetch holes, backpressures when fewer than two slots are free, no bypass.
module fetch_queue #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave fq
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   guesses_branch;
    logic [ADDR_WIDTH-1:0]  prediction;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  entry_t [1:0]    in_entry;
  entry_t          rd0, rd1;
  logic            stall, enq_en, deq_en, we0, we1;
  logic [1:0]      valid_out, n_enq, n_deq;
  logic [PtrW-1:0] wa0, wa1;

  // Backpressure depends only on registered occupancy, never on this cycle's dequeue.
  assign stall     = count_q > CntW'(DEPTH - 2);
  assign valid_out = {count_q >= CntW'(2), count_q != '0};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      in_entry[i] = '{pc:             fq.in_pc[i],
                      instr:          fq.in_instr[i],
                      guesses_branch: fq.in_guesses_branch[i],
                      prediction:     fq.in_prediction[i]};
    end
  end

  assign rd0 = mem_q[head_q];
  assign rd1 = mem_q[head_q + PtrW'(1)];

  assign fq.fq_stall           = stall;
  assign fq.out_valid          = valid_out;
  assign fq.out_pc             = {rd1.pc, rd0.pc};
  assign fq.out_instr          = {rd1.instr, rd0.instr};
  assign fq.out_guesses_branch = {rd1.guesses_branch, rd0.guesses_branch};
  assign fq.out_prediction     = {rd1.prediction, rd0.prediction};
  assign fq.count              = count_q;

  always_comb begin
    enq_en  = ~stall & ~fq.ext_flush & ~reset;
    deq_en  = ~fq.ext_stall & ~fq.ext_flush & ~reset;
    n_enq   = enq_en ? ({1'b0, fq.in_valid[0]} + {1'b0, fq.in_valid[1]}) : 2'd0;
    // Decode takes both presented entries or none.
    n_deq   = deq_en ? ({1'b0, valid_out[0]} + {1'b0, valid_out[1]}) : 2'd0;
    we0     = enq_en & fq.in_valid[0];
    we1     = enq_en & fq.in_valid[1];
    // A lone slot 1 lands at tail, closing the hole.
    wa0     = tail_q;
    wa1     = tail_q + PtrW'(fq.in_valid[0]);
    tail_d  = tail_q + PtrW'(n_enq);
    head_d  = head_q + PtrW'(n_deq);
    count_d = count_q + CntW'(n_enq) - CntW'(n_deq);
  end

  always_ff @(posedge clk) begin
    if (reset || fq.ext_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left uncleared on reset/flush; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (we0) mem_q[wa0] <= in_entry[0];
    if (we1) mem_q[wa1] <= in_entry[1];
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .INSTR_WIDTH(32)) fq_if ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .INSTR_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq_if)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        gb;
    logic [31:0] pred;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;

  // Apply one cycle of inputs and advance the reference model across the coming edge.
  task automatic drive(input logic r, input logic f, input logic s, input logic [1:0] v,
                       input logic [31:0] p0, input logic [31:0] p1);
    ent_t e[2];
    int   n;
    e[0].pc = p0;
    e[1].pc = p1;
    for (int i = 0; i < 2; i++) begin
      e[i].instr = $urandom;
      e[i].gb    = 1'($urandom);
      e[i].pred  = $urandom;
    end
    reset            = r;
    fq_if.ext_flush  = f;
    fq_if.ext_stall  = s;
    fq_if.in_valid   = v;
    for (int i = 0; i < 2; i++) begin
      fq_if.in_pc[i]             = e[i].pc;
      fq_if.in_instr[i]          = e[i].instr;
      fq_if.in_guesses_branch[i] = e[i].gb;
      fq_if.in_prediction[i]     = e[i].pred;
    end
    if (r || f) begin
      mq.delete();
    end else begin
      n = mq.size();
      if (!s) for (int k = 0; k < ((n >= 2) ? 2 : n); k++) void'(mq.pop_front());
      if (n <= int'(DEPTH) - 2) begin
        if (v[0]) mq.push_back(e[0]);
        if (v[1]) mq.push_back(e[1]);
      end
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 2'b11, 32'hdead0000, 32'hdead0004);
    @(negedge clk);
    drive(1, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    checks++; if (fq_if.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fq_if.count); end
    checks++; if (fq_if.out_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", fq_if.out_valid); end
    checks++; if (fq_if.fq_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", fq_if.fq_stall); end
  endtask

  task automatic test_pass_through();
    drive(0, 0, 0, 2'b11, 32'h10, 32'h14);
    @(negedge clk);
    checks++; if (fq_if.out_valid !== 2'b11) begin errors++; $display("FAIL pass_valid got %b want 11", fq_if.out_valid); end
    checks++; if (fq_if.out_pc[0] !== 32'h10 || fq_if.out_pc[1] !== 32'h14) begin errors++; $display("FAIL pass_pc got %h/%h want 10/14", fq_if.out_pc[0], fq_if.out_pc[1]); end
    checks++; if (fq_if.count !== 4'd2) begin errors++; $display("FAIL pass_count got %0d want 2", fq_if.count); end
    drive(0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    checks++; if (fq_if.count !== 4'd0 || fq_if.out_valid !== 2'b00) begin errors++; $display("FAIL pass_drain got count %0d valid %b want 0 00", fq_if.count, fq_if.out_valid); end
  endtask

  task automatic test_hole();
    drive(0, 0, 1, 2'b10, 32'hbad0, 32'h24);
    @(negedge clk);
    drive(0, 0, 1, 2'b11, 32'h28, 32'h2c);
    @(negedge clk);
    checks++; if (fq_if.count !== 4'd3) begin errors++; $display("FAIL hole_count got %0d want 3", fq_if.count); end
    checks++; if (fq_if.out_pc[0] !== 32'h24 || fq_if.out_pc[1] !== 32'h28) begin errors++; $display("FAIL hole_pc got %h/%h want 24/28", fq_if.out_pc[0], fq_if.out_pc[1]); end
    drive(0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    checks++; if (fq_if.out_valid !== 2'b01 || fq_if.out_pc[0] !== 32'h2c) begin errors++; $display("FAIL hole_tail got valid %b pc %h want 01 2c", fq_if.out_valid, fq_if.out_pc[0]); end
    drive(0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    checks++; if (fq_if.count !== 4'd0) begin errors++; $display("FAIL hole_empty got %0d want 0", fq_if.count); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 2'b11, 32'h200 + 32'(8 * k), 32'h204 + 32'(8 * k));
      @(negedge clk);
      checks++; if (fq_if.count !== 4'(2 * (k + 1))) begin errors++; $display("FAIL fill_count got %0d want %0d", fq_if.count, 2 * (k + 1)); end
      checks++; if (fq_if.fq_stall !== (k == 3)) begin errors++; $display("FAIL fill_stall got %b want %b", fq_if.fq_stall, k == 3); end
    end
    drive(0, 0, 1, 2'b11, 32'h300, 32'h304);
    @(negedge clk);
    checks++; if (fq_if.count !== 4'd8) begin errors++; $display("FAIL full_hold got %0d want 8", fq_if.count); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (fq_if.out_pc[0] !== 32'h200 + 32'(8 * k) || fq_if.out_pc[1] !== 32'h204 + 32'(8 * k)) begin errors++; $display("FAIL fill_order got %h/%h want %h", fq_if.out_pc[0], fq_if.out_pc[1], 32'h200 + 32'(8 * k)); end
      drive(0, 0, 0, 2'b00, 0, 0);
      @(negedge clk);
    end
    checks++; if (fq_if.count !== 4'd0) begin errors++; $display("FAIL fill_drain got %0d want 0", fq_if.count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 2'b11, 32'h1000 + 32'(8 * i), 32'h1004 + 32'(8 * i));
      @(negedge clk);
      checks++; if (fq_if.count !== 4'd2 || fq_if.out_valid !== 2'b11) begin errors++; $display("FAIL b2b_count got %0d valid %b want 2 11", fq_if.count, fq_if.out_valid); end
      checks++; if (fq_if.out_pc[0] !== 32'h1000 + 32'(8 * i) || fq_if.out_pc[1] !== 32'h1004 + 32'(8 * i)) begin errors++; $display("FAIL b2b_pc got %h/%h want %h", fq_if.out_pc[0], fq_if.out_pc[1], 32'h1000 + 32'(8 * i)); end
    end
    drive(0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    checks++; if (fq_if.count !== 4'd0) begin errors++; $display("FAIL b2b_drain got %0d want 0", fq_if.count); end
  endtask

  task automatic test_flush();
    drive(0, 0, 1, 2'b11, 32'h400, 32'h404);
    @(negedge clk);
    drive(0, 0, 1, 2'b11, 32'h408, 32'h40c);
    @(negedge clk);
    drive(0, 0, 1, 2'b01, 32'h410, 32'h0);
    @(negedge clk);
    checks++; if (fq_if.count !== 4'd5) begin errors++; $display("FAIL flush_pre got %0d want 5", fq_if.count); end
    drive(0, 1, 0, 2'b11, 32'h900, 32'h904);
    @(negedge clk);
    checks++; if (fq_if.count !== 4'd0 || fq_if.out_valid !== 2'b00 || fq_if.fq_stall !== 1'b0) begin errors++; $display("FAIL flush_clear got count %0d valid %b stall %b want 0 00 0", fq_if.count, fq_if.out_valid, fq_if.fq_stall); end
    drive(0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    checks++; if (fq_if.count !== 4'd0 || fq_if.out_valid !== 2'b00) begin errors++; $display("FAIL flush_drop got count %0d valid %b want 0 00", fq_if.count, fq_if.out_valid); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 2'b11, 32'h500 + 32'(8 * k), 32'h504 + 32'(8 * k));
      @(negedge clk);
    end
    checks++; if (fq_if.count !== 4'd6) begin errors++; $display("FAIL rstmid_pre got %0d want 6", fq_if.count); end
    drive(1, 0, 1, 2'b11, 32'h600, 32'h604);
    @(negedge clk);
    checks++; if (fq_if.count !== 4'd0 || fq_if.out_valid !== 2'b00) begin errors++; $display("FAIL rstmid_clear got count %0d valid %b want 0 00", fq_if.count, fq_if.out_valid); end
    drive(0, 0, 1, 2'b11, 32'h100, 32'h104);
    @(negedge clk);
    checks++; if (fq_if.out_valid !== 2'b11 || fq_if.out_pc[0] !== 32'h100 || fq_if.out_pc[1] !== 32'h104) begin errors++; $display("FAIL rstmid_first got valid %b pc %h/%h want 11 100/104", fq_if.out_valid, fq_if.out_pc[0], fq_if.out_pc[1]); end
    drive(0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_random();
    int n;
    for (int c = 0; c < 600; c++) begin
      n = mq.size();
      checks++; if (fq_if.count !== 4'(n) || fq_if.count > 4'(DEPTH)) begin errors++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, fq_if.count, n); end
      checks++; if (fq_if.out_valid !== {n >= 2, n >= 1}) begin errors++; $display("FAIL rand_valid cyc %0d got %b want %b", c, fq_if.out_valid, {n >= 2, n >= 1}); end
      checks++; if (fq_if.fq_stall !== (n > int'(DEPTH) - 2)) begin errors++; $display("FAIL rand_stall cyc %0d got %b want %b", c, fq_if.fq_stall, n > int'(DEPTH) - 2); end
      for (int j = 0; j < 2 && j < n; j++) begin
        checks++;
        if ({fq_if.out_pc[j], fq_if.out_instr[j], fq_if.out_guesses_branch[j], fq_if.out_prediction[j]}
            !== {mq[j].pc, mq[j].instr, mq[j].gb, mq[j].pred}) begin
          errors++;
          $display("FAIL rand_entry cyc %0d slot %0d got pc %h instr %h gb %b pred %h want pc %h instr %h gb %b pred %h",
                   c, j, fq_if.out_pc[j], fq_if.out_instr[j], fq_if.out_guesses_branch[j], fq_if.out_prediction[j],
                   mq[j].pc, mq[j].instr, mq[j].gb, mq[j].pred);
        end
      end
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
            (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            2'($urandom), $urandom & 32'hffff_fffc, $urandom & 32'hffff_fffc);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_hole();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
